pipeline_ctrl_unit: RTL and testbench

//  Sequencing/hazard controller for the 5-stage MIPS pipeline. Drives PC enable, IF/ID enable+flush,
//  ID/EX bubble and global stage enable. Supports debug run/step/halt and load-use stalls.

---
 rtl/pipe_ctrl_pkg.sv | 16 +
 rtl/pipeline_ctrl_unit_load_use_detect.sv | 16 +
 rtl/pipeline_ctrl_unit.sv | 126 ++++++++++++
 tb/tb_pipeline_ctrl_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and constants for the 5-stage pipeline sequencing controller.
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_DRAIN  = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  localparam int          DRAIN_CYCLES = 3;
  localparam logic [1:0]  DRAIN_LOAD   = 2'(DRAIN_CYCLES);
  localparam logic [31:0] NOP_WORD     = 32'h0000_0000;

endpackage

// File: rtl/pipeline_ctrl_unit_load_use_detect.sv
// Load-use hazard compare: a load in EX whose destination feeds the instruction in ID.
module load_use_detect #(
  parameter int NREG = 5
) (
  input  logic            i_ex_memread,
  input  logic [NREG-1:0] i_ex_rt,
  input  logic [NREG-1:0] i_id_rs,
  input  logic [NREG-1:0] i_id_rt,
  output logic            o_stall
);

  // $zero is never a real dependency, so a load targeting it cannot stall.
  assign o_stall = i_ex_memread && (i_ex_rt != '0) &&
                   ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));

endmodule

// File: rtl/pipeline_ctrl_unit.sv
// Pipeline sequencing/hazard controller: debug run/step/halt FSM, HALT drain and cycle counter.
// Define PIPE_CTRL_HAZARD_DETECT_EN to enable hardware load-use stalls (otherwise stall is tied 0).
module pipeline_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int NBITS    = 32,
  parameter int NREG     = 5,
  parameter int CNT_BITS = 32
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_step,
  input  logic                i_halt_req,
  input  logic [NREG-1:0]     i_id_rs,
  input  logic [NREG-1:0]     i_id_rt,
  input  logic                i_ex_memread,
  input  logic [NREG-1:0]     i_ex_rt,
  input  logic                i_branch_taken,
  input  logic                i_jump,
  output logic                o_pc_en,
  output logic                o_ifid_en,
  output logic                o_ifid_flush,
  output logic                o_idex_bubble,
  output logic                o_pipe_en,
  output logic                o_running,
  output logic                o_halted,
  output logic [CNT_BITS-1:0] o_cycle_cnt
);

`ifdef PIPE_CTRL_HAZARD_DETECT_EN
  localparam logic HAZARD_EN = 1'b1;
`else
  localparam logic HAZARD_EN = 1'b0;
`endif

  state_t              state_q, state_d;
  logic [1:0]          drain_q, drain_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                step_prev_q, step_prev_d;

  logic load_use;
  logic stall;
  logic flush;
  logic step_rise;
  logic adv;
  logic halt_ok;

  load_use_detect #(.NREG(NREG)) u_load_use_detect (
    .i_ex_memread (i_ex_memread),
    .i_ex_rt      (i_ex_rt),
    .i_id_rs      (i_id_rs),
    .i_id_rt      (i_id_rt),
    .o_stall      (load_use)
  );

  assign stall     = HAZARD_EN & load_use;
  assign flush     = (i_branch_taken | i_jump) & ~stall;
  assign step_rise = i_step & ~step_prev_q;
  assign adv       = (state_q == S_RUN) || (state_q == S_STEP) || (state_q == S_DRAIN);
  // A stalled HALT has not really been accepted yet; it must wait for the load to clear.
  assign halt_ok   = i_halt_req & ~stall;

  always_comb begin
    state_d       = state_q;
    drain_d       = drain_q;
    cnt_d         = cnt_q;
    step_prev_d   = i_step;
    o_pc_en       = 1'b0;
    o_ifid_en     = 1'b0;
    o_ifid_flush  = 1'b0;
    o_idex_bubble = 1'b0;
    o_pipe_en     = 1'b0;

    if (adv) cnt_d = cnt_q + CNT_BITS'(1);

    case (state_q)
      S_IDLE: begin
        if (i_start)        state_d = S_RUN;
        else if (step_rise) state_d = S_STEP;
      end
      S_RUN, S_STEP: begin
        o_pc_en       = ~stall;
        o_ifid_en     = ~stall;
        o_idex_bubble = stall;
        o_ifid_flush  = flush;
        o_pipe_en     = 1'b1;
        if (halt_ok) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_LOAD;
        end else if (state_q == S_STEP) begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        // Fetch is frozen and NOPs flow in behind the HALT until it retires.
        o_ifid_en    = 1'b1;
        o_ifid_flush = 1'b1;
        o_pipe_en    = 1'b1;
        drain_d      = drain_q - 2'd1;
        if (drain_q == 2'd1) state_d = S_HALTED;
      end
      S_HALTED: ;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      drain_q     <= 2'd0;
      cnt_q       <= '0;
      step_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      cnt_q       <= cnt_d;
      step_prev_q <= step_prev_d;
    end
  end

  assign o_running   = (state_q == S_RUN);
  assign o_halted    = (state_q == S_HALTED);
  assign o_cycle_cnt = cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// Self-checking bench for pipeline_ctrl_unit: directed scenarios then random stimulus vs a behavioural model.
module tb_pipeline_ctrl_unit;

`ifdef PIPE_CTRL_HAZARD_DETECT_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_start, i_step, i_halt_req;
  logic [4:0]  i_id_rs, i_id_rt, i_ex_rt;
  logic        i_ex_memread, i_branch_taken, i_jump;
  logic        o_pc_en, o_ifid_en, o_ifid_flush, o_idex_bubble, o_pipe_en;
  logic        o_running, o_halted;
  logic [31:0] o_cycle_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: what the controller is doing, not how it encodes it.
  bit          m_run, m_step, m_halted, m_step_prev;
  int          m_drain;
  logic [31:0] m_cnt;

  always #5 i_clk = ~i_clk;

  pipeline_ctrl_unit #(.NBITS(32), .NREG(5), .CNT_BITS(32)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_start        (i_start),
    .i_step         (i_step),
    .i_halt_req     (i_halt_req),
    .i_id_rs        (i_id_rs),
    .i_id_rt        (i_id_rt),
    .i_ex_memread   (i_ex_memread),
    .i_ex_rt        (i_ex_rt),
    .i_branch_taken (i_branch_taken),
    .i_jump         (i_jump),
    .o_pc_en        (o_pc_en),
    .o_ifid_en      (o_ifid_en),
    .o_ifid_flush   (o_ifid_flush),
    .o_idex_bubble  (o_idex_bubble),
    .o_pipe_en      (o_pipe_en),
    .o_running      (o_running),
    .o_halted       (o_halted),
    .o_cycle_cnt    (o_cycle_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_stall();
    return HZ && i_ex_memread && (i_ex_rt != 0) && (i_ex_rt == i_id_rs || i_ex_rt == i_id_rt);
  endfunction

  task automatic model_reset();
    m_run = 0; m_step = 0; m_halted = 0; m_step_prev = 0; m_drain = 0; m_cnt = 0;
  endtask

  task automatic check_outputs();
    bit st, adv;
    bit e_pc, e_ifid, e_fl, e_bub, e_pipe;
    st  = m_stall();
    adv = m_run || m_step || (m_drain > 0);
    e_pc = 0; e_ifid = 0; e_fl = 0; e_bub = 0; e_pipe = 0;
    if (m_drain > 0) begin
      e_ifid = 1; e_fl = 1; e_pipe = 1;
    end else if (adv) begin
      e_pc = !st; e_ifid = !st; e_bub = st; e_pipe = 1;
      e_fl = (i_branch_taken || i_jump) && !st;
    end
    check_eq("pc_en",       32'(o_pc_en),       32'(e_pc));
    check_eq("ifid_en",     32'(o_ifid_en),     32'(e_ifid));
    check_eq("ifid_flush",  32'(o_ifid_flush),  32'(e_fl));
    check_eq("idex_bubble", 32'(o_idex_bubble), 32'(e_bub));
    check_eq("pipe_en",     32'(o_pipe_en),     32'(e_pipe));
    check_eq("running",     32'(o_running),     32'(m_run));
    check_eq("halted",      32'(o_halted),      32'(m_halted));
    check_eq("cycle_cnt",   o_cycle_cnt,        m_cnt);
  endtask

  task automatic model_clock();
    bit st, rise, adv;
    st   = m_stall();
    rise = i_step && !m_step_prev;
    adv  = m_run || m_step || (m_drain > 0);
    m_step_prev = i_step;
    if (adv) m_cnt = m_cnt + 1;
    if (m_drain > 0) begin
      m_drain = m_drain - 1;
      if (m_drain == 0) m_halted = 1;
    end else if (m_run || m_step) begin
      if (i_halt_req && !st) begin
        m_run = 0; m_step = 0; m_drain = 3;
      end else begin
        m_step = 0;
      end
    end else if (!m_halted) begin
      if (i_start) m_run = 1;
      else if (rise) m_step = 1;
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
    check_outputs();
    model_clock();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clr_inputs();
    i_start = 0; i_step = 0; i_halt_req = 0;
    i_id_rs = 0; i_id_rt = 0; i_ex_rt = 0;
    i_ex_memread = 0; i_branch_taken = 0; i_jump = 0;
  endtask

  task automatic do_reset();
    i_rst_n = 0;
    #1;
    model_reset();
    check_eq("rst_pc_en",   32'(o_pc_en),       32'd0);
    check_eq("rst_ifid_en", 32'(o_ifid_en),     32'd0);
    check_eq("rst_flush",   32'(o_ifid_flush),  32'd0);
    check_eq("rst_bubble",  32'(o_idex_bubble), 32'd0);
    check_eq("rst_pipe_en", 32'(o_pipe_en),     32'd0);
    check_eq("rst_running", 32'(o_running),     32'd0);
    check_eq("rst_halted",  32'(o_halted),      32'd0);
    check_eq("rst_cnt",     o_cycle_cnt,        32'd0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1;
  endtask

  initial begin
    clr_inputs();
    i_rst_n = 0;
    model_reset();
    @(posedge i_clk);
    #1;
    do_reset();

    // Start from idle, then free run.
    i_start = 1; tick(); i_start = 0;
    repeat (4) tick();

    // Load-use hazard, then a load to $zero.
    i_ex_memread = 1; i_ex_rt = 5; i_id_rs = 5; tick();
    i_ex_rt = 0; tick();
    clr_inputs();

    // Branch flush alone and with a concurrent stall.
    i_branch_taken = 1; tick();
    i_ex_memread = 1; i_ex_rt = 7; i_id_rt = 7; tick();
    clr_inputs(); i_jump = 1; tick();
    clr_inputs(); tick();

    // Held step advances once; a fresh press advances once more.
    do_reset();
    i_step = 1; repeat (5) tick();
    check_eq("step_held_cnt", o_cycle_cnt, 32'd1);
    i_step = 0; tick();
    i_step = 1; tick();
    i_step = 0; tick();
    check_eq("step_again_cnt", o_cycle_cnt, 32'd2);
    i_start = 1; i_step = 1; tick();
    clr_inputs(); tick();
    check_eq("start_wins_running", 32'(o_running), 32'd1);

    // HALT drain then halted; start ignored.
    do_reset();
    i_start = 1; tick(); i_start = 0;
    repeat (3) tick();
    i_halt_req = 1; tick(); i_halt_req = 0;
    i_start = 1; i_step = 1;
    repeat (3) tick();
    repeat (3) tick();
    check_eq("halt_state", 32'(o_halted), 32'd1);
    check_eq("halt_cnt",   o_cycle_cnt,   32'd7);
    clr_inputs();

    // Reset in the middle of draining aborts at once.
    do_reset();
    i_start = 1; tick(); i_start = 0;
    tick();
    i_halt_req = 1; tick(); i_halt_req = 0;
    tick();
    do_reset();
    tick();

    // Randomised run against the model.
    for (int c = 0; c < 4000; c++) begin
      i_start        = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) i_step = ~i_step;
      i_halt_req     = ($urandom_range(0, 29) == 0);
      i_id_rs        = 5'($urandom_range(0, 3));
      i_id_rt        = 5'($urandom_range(0, 3));
      i_ex_rt        = 5'($urandom_range(0, 3));
      i_ex_memread   = ($urandom_range(0, 2) == 0);
      i_branch_taken = ($urandom_range(0, 4) == 0);
      i_jump         = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 399) == 0 || (m_halted && $urandom_range(0, 7) == 0))
        do_reset();
      else
        tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
